// File: rtl/conv_pkg.sv
// Shared definitions for the layer-0 conv stage and the layer-1 max-pool stage:
// geometry, result-memory bus widths, csel codes and the pool FSM encoding.
package conv_pkg;

    localparam int DATA_WIDTH = 20;               // 4.16 two's-complement pixel
    localparam int IMG_W      = 64;               // layer-0 map width/height
    localparam int ADDR_W     = 12;               // result-memory address width
    localparam int POOL_W     = IMG_W / 2;        // layer-1 map width/height
    localparam int CNT_W      = $clog2(POOL_W);   // row/col counter width
    localparam int LOG_W      = $clog2(IMG_W);    // shift for one input row

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_L0   = 3'b001;
    localparam logic [2:0] SEL_L1   = 3'b011;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_W - 1);

    typedef enum logic [2:0] {
        MP_IDLE,
        MP_RD0,
        MP_RD1,
        MP_RD2,
        MP_RD3,
        MP_CAP,
        MP_WR,
        MP_DONE
    } mp_state_e;

    // All registered outputs of the pool stage, kept together so they share
    // one reset and one register.
    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic                  crd;
        logic [ADDR_W-1:0]     caddr_rd;
        logic                  cwr;
        logic [ADDR_W-1:0]     caddr_wr;
        logic [DATA_WIDTH-1:0] cdata_wr;
        logic [2:0]            csel;
    } mp_bus_t;

    // Full-width signed maximum; on a tie the first operand is kept, which is
    // the same value either way.
    function automatic logic [DATA_WIDTH-1:0] signed_max(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Window and write address generation for the 2x2 stride-2 pool.
// Output (pr,pc) reads the four layer-0 words whose top-left is (2pr, 2pc)
// and writes layer-1 word pr*POOL_W + pc.
module maxpool_addr_gen
    import conv_pkg::*;
(
    input  logic [CNT_W-1:0]  pr_i,
    input  logic [CNT_W-1:0]  pc_i,
    output logic [ADDR_W-1:0] a0_o,
    output logic [ADDR_W-1:0] a1_o,
    output logic [ADDR_W-1:0] a2_o,
    output logic [ADDR_W-1:0] a3_o,
    output logic [ADDR_W-1:0] waddr_o
);

    // Row 2pr starts at (2pr)*IMG_W = pr << (LOG_W+1); column 2pc is pc << 1.
    // Bit 0 and bit LOG_W of a0 are always clear, so the neighbours are ORs.
    assign a0_o    = (ADDR_W'(pr_i) << (LOG_W + 1)) | (ADDR_W'(pc_i) << 1);
    assign a1_o    = a0_o | ADDR_W'(1);
    assign a2_o    = a0_o | ADDR_W'(IMG_W);
    assign a3_o    = a2_o | ADDR_W'(1);
    assign waddr_o = (ADDR_W'(pr_i) << CNT_W) | ADDR_W'(pc_i);

endmodule

// File: rtl/maxpool_l1.sv
// Layer-1 2x2 stride-2 max-pool over the 64x64 layer-0 result memory.
// Each output takes six cycles: four reads, one capture of the last read
// word, one write. All bus outputs are registered and decoded from the
// next state so they line up with the state they belong to.
module maxpool_l1
    import conv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  crd,
    output logic [ADDR_W-1:0]     caddr_rd,
    input  logic [DATA_WIDTH-1:0] cdata_rd,
    output logic                  cwr,
    output logic [ADDR_W-1:0]     caddr_wr,
    output logic [DATA_WIDTH-1:0] cdata_wr,
    output logic [2:0]            csel
);

    mp_state_e             state_q, state_d;
    logic [CNT_W-1:0]      pr_q, pr_d;
    logic [CNT_W-1:0]      pc_q, pc_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    mp_bus_t               out_q, out_d;

    logic [ADDR_W-1:0]     a0, a1, a2, a3, waddr;

    // Addresses are generated for the next window so they can be registered
    // together with the state that uses them.
    maxpool_addr_gen u_addr_gen (
        .pr_i    (pr_d),
        .pc_i    (pc_d),
        .a0_o    (a0),
        .a1_o    (a1),
        .a2_o    (a2),
        .a3_o    (a3),
        .waddr_o (waddr)
    );

    // Next-state, counter and running-maximum logic.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        pc_d    = pc_q;
        max_d   = max_q;
        unique case (state_q)
            MP_IDLE: begin
                if (start) begin
                    state_d = MP_RD0;
                    pr_d    = '0;
                    pc_d    = '0;
                end
            end
            MP_RD0: state_d = MP_RD1;
            MP_RD1: begin
                // First word of the window is loaded as-is so all-negative
                // windows never collapse to zero.
                max_d   = cdata_rd;
                state_d = MP_RD2;
            end
            MP_RD2: begin
                max_d   = signed_max(max_q, cdata_rd);
                state_d = MP_RD3;
            end
            MP_RD3: begin
                max_d   = signed_max(max_q, cdata_rd);
                state_d = MP_CAP;
            end
            MP_CAP: begin
                max_d   = signed_max(max_q, cdata_rd);
                state_d = MP_WR;
            end
            MP_WR: begin
                if (pc_q != CNT_LAST) begin
                    pc_d    = pc_q + CNT_W'(1);
                    state_d = MP_RD0;
                end else begin
                    pc_d = '0;
                    if (pr_q != CNT_LAST) begin
                        pr_d    = pr_q + CNT_W'(1);
                        state_d = MP_RD0;
                    end else begin
                        state_d = MP_DONE;
                    end
                end
            end
            MP_DONE: state_d = MP_IDLE;
            default: state_d = MP_IDLE;
        endcase
    end

    // Bus output decode from the next state; registered below.
    always_comb begin
        out_d = '0;
        unique case (state_d)
            MP_RD0: begin
                out_d.busy = 1'b1; out_d.crd = 1'b1; out_d.caddr_rd = a0; out_d.csel = SEL_L0;
            end
            MP_RD1: begin
                out_d.busy = 1'b1; out_d.crd = 1'b1; out_d.caddr_rd = a1; out_d.csel = SEL_L0;
            end
            MP_RD2: begin
                out_d.busy = 1'b1; out_d.crd = 1'b1; out_d.caddr_rd = a2; out_d.csel = SEL_L0;
            end
            MP_RD3: begin
                out_d.busy = 1'b1; out_d.crd = 1'b1; out_d.caddr_rd = a3; out_d.csel = SEL_L0;
            end
            MP_CAP: begin
                out_d.busy = 1'b1; out_d.csel = SEL_L0;
            end
            MP_WR: begin
                out_d.busy     = 1'b1;
                out_d.cwr      = 1'b1;
                out_d.caddr_wr = waddr;
                out_d.cdata_wr = max_d;
                out_d.csel     = SEL_L1;
            end
            MP_DONE: out_d.done = 1'b1;
            default: out_d = '0;
        endcase
    end

    // State, counters, maximum and output registers; reset aborts any run.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MP_IDLE;
            pr_q    <= '0;
            pc_q    <= '0;
            max_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            pc_q    <= pc_d;
            max_q   <= max_d;
            out_q   <= out_d;
        end
    end

    assign busy     = out_q.busy;
    assign done     = out_q.done;
    assign crd      = out_q.crd;
    assign caddr_rd = out_q.caddr_rd;
    assign cwr      = out_q.cwr;
    assign caddr_wr = out_q.caddr_wr;
    assign cdata_wr = out_q.cdata_wr;
    assign csel     = out_q.csel;

endmodule

// File: tb/tb_maxpool_l1.sv
// Scoreboard bench for maxpool_l1: the driver loads the layer-0 memory model
// and queues the expected layer-1 writes; a monitor compares every write and
// checks the bus protocol each cycle.
module tb_maxpool_l1;
    import conv_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  busy, done, crd, cwr;
    logic [ADDR_W-1:0]     caddr_rd, caddr_wr;
    logic [DATA_WIDTH-1:0] cdata_rd, cdata_wr;
    logic [2:0]            csel;

    maxpool_l1 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;

    // Layer-0 memory model: read data appears one cycle after crd.
    logic [DATA_WIDTH-1:0] mem [4096];
    initial cdata_rd = '0;
    always @(posedge clk) if (crd) cdata_rd <= mem[caddr_rd];

    typedef struct {
        logic [ADDR_W-1:0]     addr;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int wr_count, first_wr_rel, last_wr_rel, done_rel;
    bit done_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol checks every cycle, scoreboard compare on each write.
    always @(negedge clk) begin
        int rel;
        exp_t e;
        rel = cyc - start_cyc + 1;
        check("crd_cwr_excl", 64'(crd & cwr), 64'(0));
        if (crd) check("csel_on_rd", 64'(csel), 64'(SEL_L0));
        if (cwr) check("csel_on_wr", 64'(csel), 64'(SEL_L1));
        if (!busy)
            check("idle_bus_zero", 64'({crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}), 64'(0));
        if (done) begin
            done_seen = 1'b1;
            done_rel  = rel;
        end
        if (cwr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 64'(caddr_wr), 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(caddr_wr), 64'(e.addr));
                check("wr_data", 64'(cdata_wr), 64'(e.data));
            end
            check("busy_on_wr", 64'(busy), 64'(1));
            if (wr_count == 0) first_wr_rel = rel;
            last_wr_rel = rel;
            wr_count++;
        end
    end

    task automatic set_win(input int r, input int c, input logic [19:0] v0,
                           input logic [19:0] v1, input logic [19:0] v2, input logic [19:0] v3);
        int base;
        base = (2 * r) * 64 + 2 * c;
        mem[base]      = v0;
        mem[base + 1]  = v1;
        mem[base + 64] = v2;
        mem[base + 65] = v3;
    endtask

    task automatic load_ramp();
        exp_t e;
        for (int a = 0; a < 4096; a++) mem[a] = 20'(a);
        exp_q.delete();
        for (int k = 0; k < 1024; k++) begin
            e.addr = 12'(k);
            e.data = 20'((2 * (k / 32) + 1) * 64 + 2 * (k % 32) + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic load_spikes();
        logic [19:0] exp_data [1024];
        exp_t e;
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        for (int k = 0; k < 1024; k++) exp_data[k] = '0;
        set_win(0, 0, 20'd7, 20'd3, 20'd9, 20'd1);                         exp_data[0]    = 20'd9;
        set_win(31, 31, 20'd0, 20'd0, 20'd0, 20'h7FFFF);                   exp_data[1023] = 20'h7FFFF;
        set_win(5, 5, 20'hFFFFB, 20'hFFFFD, 20'hFFFF8, 20'hFFFFD);         exp_data[165]  = 20'hFFFFD;
        set_win(2, 0, 20'h00100, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);         exp_data[64]   = 20'h00100;
        set_win(2, 1, 20'hFFFFF, 20'h00101, 20'hFFFFF, 20'hFFFFF);         exp_data[65]   = 20'h00101;
        set_win(2, 2, 20'hFFFFF, 20'hFFFFF, 20'h00102, 20'hFFFFF);         exp_data[66]   = 20'h00102;
        set_win(2, 3, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'h00103);         exp_data[67]   = 20'h00103;
        set_win(6, 6, 20'hFFFF9, 20'hFFFF9, 20'hFFFF9, 20'hFFFF9);         exp_data[198]  = 20'hFFFF9;
        set_win(10, 3, 20'h80000, 20'h00001, 20'h80000, 20'h80000);        exp_data[323]  = 20'h00001;
        exp_q.delete();
        for (int k = 0; k < 1024; k++) begin
            e.addr = 12'(k);
            e.data = exp_data[k];
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        wr_count     = 0;
        first_wr_rel = -1;
        last_wr_rel  = -1;
        done_rel     = -1;
        done_seen    = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        start_cyc = cyc;
    endtask

    // Runs one full job and checks its write count and timing.
    task automatic run_job(input bit extra_starts);
        int rel;
        pulse_start();
        for (int i = 0; i < 7000 && !done_seen; i++) begin
            @(negedge clk);
            rel   = cyc - start_cyc + 1;
            start = extra_starts && (rel == 100 || rel == 3000);
        end
        start = 1'b0;
        check("done_seen", 64'(done_seen), 64'(1));
        @(negedge clk);
        check("done_one_cycle", 64'({busy, done}), 64'(0));
        check("first_wr_cycle", 64'(first_wr_rel), 64'(6));
        check("last_wr_cycle", 64'(last_wr_rel), 64'(6144));
        check("done_cycle", 64'(done_rel), 64'(6145));
        check("wr_count", 64'(wr_count), 64'(1024));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}), 64'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp: every window maximum is its bottom-right word.
        load_ramp();
        run_job(1'b0);

        // Spikes, negatives and extra starts while busy.
        load_spikes();
        run_job(1'b1);

        // Asynchronous reset mid-run, then a clean restart.
        load_ramp();
        pulse_start();
        repeat (1999) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset_out", 64'({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}), 64'(0));
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 64'({busy, done, crd, cwr}), 64'(0));
        load_ramp();
        run_job(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/maxpool_l1.md
Name: maxpool_l1

Overview:
Layer-1 stage that runs directly downstream of the layer-0 convolution/ReLU engine. It performs 2x2, stride-2 max-pooling over the 64x64 layer-0 result memory (csel L0) and writes the 32x32 pooled map to layer-1 memory (csel L1). It shares the result-memory bus with the conv stage; the top-level mux grants the bus to this block while its busy is high.

Parameters:
DATA_WIDTH, 20, pixel word width, two's-complement 4.16 fixed point
IMG_W, 64, input map width/height, power of two
ADDR_W, 12, result-memory address width
SEL_L0, 3'b001, csel code for layer-0 memory
SEL_L1, 3'b011, csel code for layer-1 memory

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse from conv stage: L0 memory complete
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last L1 write
crd  output  1  result-memory read strobe
caddr_rd  output  ADDR_W  read address
cdata_rd  input  DATA_WIDTH  read data, valid one cycle after crd
cwr  output  1  result-memory write strobe
caddr_wr  output  ADDR_W  write address
cdata_wr  output  DATA_WIDTH  write data
csel  output  3  memory select

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, crd, cwr = 0; caddr_rd, caddr_wr, cdata_wr, csel = 0; row/col counters and max register cleared. Reset mid-run aborts without completing the in-flight write.
- States: IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE.
- IDLE: all bus outputs 0. start=1 -> RD0, counters pr=pc=0. start is ignored in every other state.
- Window for output (pr,pc), pr,pc in 0..IMG_W/2-1: read addresses a0=(2pr)*IMG_W+2pc, a1=a0+1, a2=a0+IMG_W, a3=a0+IMG_W+1.
- RD0: crd=1, caddr_rd=a0, csel=SEL_L0.
- RD1: crd=1, caddr_rd=a1; max <= cdata_rd (d0, loaded directly, never compared against 0).
- RD2: crd=1, caddr_rd=a2; max <= signed_max(max, d1).
- RD3: crd=1, caddr_rd=a3; max <= signed_max(max, d2).
- CAP: crd=0, csel=SEL_L0; max <= signed_max(max, d3).
- WR: cwr=1, csel=SEL_L1, caddr_wr=pr*(IMG_W/2)+pc (upper bits 0), cdata_wr=max.
  - If pc<IMG_W/2-1: pc++, go to RD0.
  - Else pc=0. If pr<IMG_W/2-1: pr++, go to RD0. Else go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Comparison: full-width signed. On a tie, the value is unchanged (either operand gives the same result). No saturation or width change: output width equals input width.
- Outputs are registered. crd and cwr are never high in the same cycle. Outside RD*/CAP/WR, csel=0 and strobes are 0.
- Timing: start sampled at edge 0; RD0 begins at cycle 1; first cwr at cycle 6. 6 cycles per output, 1024 outputs, so the last cwr is at cycle 6144 and done at cycle 6145.
- Counters use exact log2(IMG_W/2)-bit compare; no wrap past the final pixel.

Decomposition:
- Shared package conv_pkg:
  - DATA_WIDTH, IMG_W, ADDR_W
  - SEL_L0/SEL_L1 csel codes (shared with the conv stage)
  - enumerated state constants for this FSM
- One sub-module, maxpool_addr_gen: combinational; pr/pc -> a0..a3 and the write address.
- FSM, datapath and max register stay in maxpool_l1.

Test Plan:
- Ramp: L0[a]=a for all 4096 words, pulse start -> L1[k] equals (2r+1)*64+2c+1, where r=k/32, c=k%32. Exactly 1024 cwr pulses, done at cycle 6145.
- Spike position: window (0,0) = {7,3,9,1}, window (31,31) = {0,0,0,0x7FFFF} -> L1[0]=9, L1[1023]=0x7FFFF. Spike in each of a0..a3 is detected.
- Negative values: window (5,5) = {-5,-3,-8,-3} (20-bit two's complement) -> L1[165]=0xFFFFD. All-negative window does not yield 0.
- start pulsed at cycles 100 and 3000 while busy -> ignored; write count and done timing identical to a single-start run.
- reset=0 asserted asynchronously mid-cycle at cycle 2000 -> outputs 0 immediately, busy=0. Restart after reset release completes a full correct L1 map.
- Bus protocol: monitor checks every cycle that crd and cwr are never both 1, csel=SEL_L0 whenever crd=1, csel=SEL_L1 whenever cwr=1, and all bus outputs are 0 in IDLE.
